// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter that sequences writes from N_REQ requesters into one shared register q.
// Optional feature: define RR_ARB_LOCK_EN to add the lock port for back-to-back burst writes.
module rr_reg_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        reset_p,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_W-1:0]     wdata,
`ifdef RR_ARB_LOCK_EN
    input  logic [N_REQ-1:0]            lock,
`endif
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            ack,
    output logic [$clog2(N_REQ)-1:0]    owner,
    output logic                        busy,
    output logic [DATA_W-1:0]           q
);

    localparam int OW = $clog2(N_REQ);
    localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
        logic [N_REQ-1:0] v;
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = (idx == OW'(i));
        end
        return v;
    endfunction

    state_t              state_r, state_s;
    logic [N_REQ-1:0]    gnt_r, gnt_s;
    logic [N_REQ-1:0]    ack_r, ack_s;
    logic [OW-1:0]       owner_r, owner_s;
    logic [OW-1:0]       ptr_r, ptr_s;
    logic                busy_r;
    logic [DATA_W-1:0]   q_r;
    logic                load_s;
    logic                keep_s;
    logic                win_found_s;
    logic [OW-1:0]       win_idx_s;
    int unsigned         cand_s;
    logic [DATA_W-1:0]   wdata_sel_s;

    // Lock keeps the current owner granted for another write when it still requests.
`ifdef RR_ARB_LOCK_EN
    assign keep_s = lock[owner_r] & req[owner_r];
`else
    assign keep_s = 1'b0;
`endif

    assign wdata_sel_s = wdata[int'(owner_r)*DATA_W +: DATA_W];

    // Winner search: first set req bit at or after ptr, wrapping past the last requester.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {OW{1'b0}};
        cand_s      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = (int'(ptr_r) + i) % N_REQ;
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = OW'(cand_s);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic for the req/gnt/ack sequence.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        ack_s   = {N_REQ{1'b0}};
        owner_s = owner_r;
        ptr_s   = ptr_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_s = GRANT;
                    gnt_s   = onehot(win_idx_s);
                    owner_s = win_idx_s;
                end else begin
                    gnt_s   = {N_REQ{1'b0}};
                end
            end
            GRANT: begin
                if (req[owner_r]) begin
                    state_s = WRITE;
                    ack_s   = onehot(owner_r);
                    load_s  = 1'b1;
                end else begin
                    // Withdrawal: give the grant back without writing or rotating.
                    state_s = IDLE;
                    gnt_s   = {N_REQ{1'b0}};
                end
            end
            WRITE: begin
                if (keep_s) begin
                    state_s = GRANT;
                end else begin
                    state_s = IDLE;
                    gnt_s   = {N_REQ{1'b0}};
                    ptr_s   = (owner_r == LAST_IDX) ? {OW{1'b0}} : owner_r + OW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = {N_REQ{1'b0}};
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_r <= IDLE;
            gnt_r   <= {N_REQ{1'b0}};
            ack_r   <= {N_REQ{1'b0}};
            owner_r <= {OW{1'b0}};
            ptr_r   <= {OW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            ack_r   <= ack_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Shared enable-gated register bank.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            q_r <= {DATA_W{1'b0}};
        end else if (load_s) begin
            q_r <= wdata_sel_s;
        end
    end

    assign gnt   = gnt_r;
    assign ack   = ack_r;
    assign owner = owner_r;
    assign busy  = busy_r;
    assign q     = q_r;

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Directed, table-driven bench for rr_reg_write_arbiter (N_REQ=4, DATA_W=8).
module tb_rr_reg_write_arbiter;

    logic        clk;
    logic        reset_p;
    logic [3:0]  req;
    logic [31:0] wdata;
`ifdef RR_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;

    int checks   = 0;
    int failures = 0;

    rr_reg_write_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .req     (req),
        .wdata   (wdata),
`ifdef RR_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .ack     (ack),
        .owner   (owner),
        .busy    (busy),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [7:0]  q;
        logic        busy;
        logic [1:0]  owner;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants: gnt one-hot or zero, ack contained in gnt.
    always @(negedge clk) begin
        checks++;
        if (($countones(gnt) > 1) || ((ack & ~gnt) != 4'b0000)) begin
            failures++;
            $display("FAIL invariant: gnt=%b ack=%b", gnt, ack);
        end
    end

    initial begin
        // Rotation with all four requesting, then a lone requester 2, then the 3 -> 0 wrap.
        tbl[0]  = '{4'b1111, 32'h44332211, 4'b0001, 4'b0000, 8'h00, 1'b1, 2'd0};
        tbl[1]  = '{4'b1111, 32'h44332211, 4'b0001, 4'b0001, 8'h11, 1'b1, 2'd0};
        tbl[2]  = '{4'b1110, 32'h44332211, 4'b0000, 4'b0000, 8'h11, 1'b0, 2'd0};
        tbl[3]  = '{4'b1110, 32'h44332211, 4'b0010, 4'b0000, 8'h11, 1'b1, 2'd1};
        tbl[4]  = '{4'b1110, 32'h44332211, 4'b0010, 4'b0010, 8'h22, 1'b1, 2'd1};
        tbl[5]  = '{4'b1100, 32'h44332211, 4'b0000, 4'b0000, 8'h22, 1'b0, 2'd1};
        tbl[6]  = '{4'b1100, 32'h44332211, 4'b0100, 4'b0000, 8'h22, 1'b1, 2'd2};
        tbl[7]  = '{4'b1100, 32'h44332211, 4'b0100, 4'b0100, 8'h33, 1'b1, 2'd2};
        tbl[8]  = '{4'b1000, 32'h44332211, 4'b0000, 4'b0000, 8'h33, 1'b0, 2'd2};
        tbl[9]  = '{4'b1000, 32'h44332211, 4'b1000, 4'b0000, 8'h33, 1'b1, 2'd3};
        tbl[10] = '{4'b1000, 32'h44332211, 4'b1000, 4'b1000, 8'h44, 1'b1, 2'd3};
        tbl[11] = '{4'b0000, 32'h44332211, 4'b0000, 4'b0000, 8'h44, 1'b0, 2'd3};
        tbl[12] = '{4'b0100, 32'h44A52211, 4'b0100, 4'b0000, 8'h44, 1'b1, 2'd2};
        tbl[13] = '{4'b0100, 32'h44A52211, 4'b0100, 4'b0100, 8'hA5, 1'b1, 2'd2};
        tbl[14] = '{4'b0000, 32'h44A52211, 4'b0000, 4'b0000, 8'hA5, 1'b0, 2'd2};
        tbl[15] = '{4'b1001, 32'h44A52211, 4'b1000, 4'b0000, 8'hA5, 1'b1, 2'd3};
        tbl[16] = '{4'b1001, 32'h44A52211, 4'b1000, 4'b1000, 8'h44, 1'b1, 2'd3};
        tbl[17] = '{4'b0001, 32'h44A52211, 4'b0000, 4'b0000, 8'h44, 1'b0, 2'd3};
        tbl[18] = '{4'b0001, 32'h44A52211, 4'b0001, 4'b0000, 8'h44, 1'b1, 2'd0};
        tbl[19] = '{4'b0001, 32'h44A52211, 4'b0001, 4'b0001, 8'h11, 1'b1, 2'd0};
        tbl[20] = '{4'b0000, 32'h44A52211, 4'b0000, 4'b0000, 8'h11, 1'b0, 2'd0};

        reset_p = 1'b1;
        req     = 4'b0000;
        wdata   = 32'h00000000;
`ifdef RR_ARB_LOCK_EN
        lock    = 4'b0000;
`endif
        tick();
        tick();
        chk("reset gnt", {28'd0, gnt}, 32'd0);
        chk("reset ack", {28'd0, ack}, 32'd0);
        chk("reset owner", {30'd0, owner}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset q", {24'd0, q}, 32'd0);
        reset_p = 1'b0;

        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("idle%0d q", c), {24'd0, q}, 32'd0);
            chk($sformatf("idle%0d gnt", c), {28'd0, gnt}, 32'd0);
            chk($sformatf("idle%0d ack", c), {28'd0, ack}, 32'd0);
            chk($sformatf("idle%0d busy", c), {31'd0, busy}, 32'd0);
        end

        for (int i = 0; i < 21; i++) begin
            req   = tbl[i].req;
            wdata = tbl[i].wdata;
            tick();
            chk($sformatf("row%0d gnt", i), {28'd0, gnt}, {28'd0, tbl[i].gnt});
            chk($sformatf("row%0d ack", i), {28'd0, ack}, {28'd0, tbl[i].ack});
            chk($sformatf("row%0d q", i), {24'd0, q}, {24'd0, tbl[i].q});
            chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
            chk($sformatf("row%0d owner", i), {30'd0, owner}, {30'd0, tbl[i].owner});
        end

        // Withdrawal in GRANT: requester 1 (ptr=1) drops req, no write, ptr stays at 1.
        wdata = 32'h44332299;
        req   = 4'b0010;
        tick();
        chk("wd grant gnt", {28'd0, gnt}, 32'h2);
        req = 4'b0000;
        tick();
        chk("wd gnt", {28'd0, gnt}, 32'h0);
        chk("wd q", {24'd0, q}, 32'h11);
        chk("wd busy", {31'd0, busy}, 32'd0);
        chk("wd ack", {28'd0, ack}, 32'h0);
        req = 4'b0011;
        tick();
        chk("wd ptr owner", {30'd0, owner}, 32'd1);
        chk("wd ptr gnt", {28'd0, gnt}, 32'h2);
        tick();
        chk("wd write q", {24'd0, q}, 32'h22);
        chk("wd write ack", {28'd0, ack}, 32'h2);

        // Asynchronous reset in the middle of WRITE.
        reset_p = 1'b1;
        #1;
        chk("async q", {24'd0, q}, 32'd0);
        chk("async ack", {28'd0, ack}, 32'd0);
        chk("async busy", {31'd0, busy}, 32'd0);
        chk("async gnt", {28'd0, gnt}, 32'd0);
        chk("async owner", {30'd0, owner}, 32'd0);
        req = 4'b0000;
        tick();
        reset_p = 1'b0;
        tick();

`ifdef RR_ARB_LOCK_EN
        // Burst by requester 0 under lock, then rotation to requester 1.
        lock  = 4'b0001;
        req   = 4'b0011;
        wdata = 32'h00000001;
        tick();
        chk("lk g0 gnt", {28'd0, gnt}, 32'h1);
        tick();
        chk("lk w0 q", {24'd0, q}, 32'h01);
        chk("lk w0 ack", {28'd0, ack}, 32'h1);
        wdata = 32'h00000002;
        tick();
        chk("lk g1 gnt", {28'd0, gnt}, 32'h1);
        chk("lk g1 ack", {28'd0, ack}, 32'h0);
        tick();
        chk("lk w1 q", {24'd0, q}, 32'h02);
        wdata = 32'h00000003;
        tick();
        chk("lk g2 gnt", {28'd0, gnt}, 32'h1);
        tick();
        chk("lk w2 q", {24'd0, q}, 32'h03);
        chk("lk w2 ack", {28'd0, ack}, 32'h1);
        lock = 4'b0000;
        req  = 4'b0010;
        tick();
        chk("lk idle gnt", {28'd0, gnt}, 32'h0);
        tick();
        chk("lk rot gnt", {28'd0, gnt}, 32'h2);
        chk("lk rot owner", {30'd0, owner}, 32'd1);
        req = 4'b0000;
        tick();
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
